// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// loads the returned word into the IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned               ADDRESS_WIDTH = 32,
  parameter int unsigned               DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0,
  parameter logic [DATA_WIDTH-1:0]     NOP_INSTR     = 32'h0000_0013
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stall_f_i,
  input  logic                     stall_d_i,
  input  logic                     flush_d_i,
  input  logic                     pc_src_e_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e_i,
  input  logic [DATA_WIDTH-1:0]    instr_i,
  output logic [ADDRESS_WIDTH-1:0] pc_f_o,
  output logic [DATA_WIDTH-1:0]    instr_d_o,
  output logic [ADDRESS_WIDTH-1:0] pc_d_o,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d_o,
  output logic                     valid_d_o,
  output logic                     misaligned_o
);

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic [ADDRESS_WIDTH-1:0] pc_next;
  logic [ADDRESS_WIDTH-1:0] target_aligned;
  logic                     target_misaligned;

  // Plain modular add: the PC wraps from the top of the address space to 0.
  assign pc_plus4          = pc + ADDRESS_WIDTH'(4);
  assign target_aligned    = {pc_target_e_i[ADDRESS_WIDTH-1:2], 2'b00};
  assign target_misaligned = |pc_target_e_i[1:0];

  // Next-PC select: redirect from Execute outranks a fetch stall.
  always_comb begin
    pc_next = pc_plus4;
    if (pc_src_e_i)     pc_next = target_aligned;
    else if (stall_f_i) pc_next = pc;
  end

  // PC register and misaligned-redirect flag; the flag only reports, the
  // fetch itself always goes to the word-aligned target.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc           <= RESET_PC;
      misaligned_o <= 1'b0;
    end else begin
      pc           <= pc_next;
      misaligned_o <= pc_src_e_i & target_misaligned;
    end
  end

  // IF/ID register: flush inserts a bubble even when decode is stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_d_i) begin
      instr_d_o    <= NOP_INSTR;
      pc_d_o       <= '0;
      pc_plus4_d_o <= '0;
      valid_d_o    <= 1'b0;
    end else if (!stall_d_i) begin
      instr_d_o    <= instr_i;
      pc_d_o       <= pc;
      pc_plus4_d_o <= pc_plus4;
      valid_d_o    <= 1'b1;
    end
  end

  // Memory address comes straight from the register: no input-to-PC path.
  assign pc_f_o = pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: ROM model on the fetch address, a cycle model of the
// stage's architectural behaviour, and directed checks along the test plan.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] instr;
  logic [31:0] pc_f, instr_d, pc_d, pc_p4_d;
  logic        valid_d, misaligned;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_f_i(stall_f), .stall_d_i(stall_d),
    .flush_d_i(flush_d), .pc_src_e_i(pc_src), .pc_target_e_i(target),
    .instr_i(instr), .pc_f_o(pc_f), .instr_d_o(instr_d), .pc_d_o(pc_d),
    .pc_plus4_d_o(pc_p4_d), .valid_d_o(valid_d), .misaligned_o(misaligned)
  );

  always #5 clk = ~clk;

  // Word-indexed ROM: word k holds 0x1000_0000 + k.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign instr = rom(pc_f);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, stated in architectural terms.
  logic [31:0] m_pc, m_instr, m_pcd, m_p4;
  logic        m_valid, m_mis;
  logic        m_ok = 1'b0;

  // Advance the model on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 32'h0; m_instr <= NOP; m_pcd <= 32'h0; m_p4 <= 32'h0;
      m_valid <= 1'b0; m_mis <= 1'b0; m_ok <= 1'b1;
    end else begin
      m_mis <= pc_src && (target % 4 != 0);
      if (pc_src)        m_pc <= target - (target % 4);
      else if (!stall_f) m_pc <= m_pc + 32'd4;
      if (flush_d) begin
        m_instr <= NOP; m_pcd <= 32'h0; m_p4 <= 32'h0; m_valid <= 1'b0;
      end else if (!stall_d) begin
        m_instr <= rom(m_pc); m_pcd <= m_pc; m_p4 <= m_pc + 32'd4; m_valid <= 1'b1;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_ok) begin
      check("m_pc_f",    pc_f,    m_pc);
      check("m_instr_d", instr_d, m_instr);
      check("m_pc_d",    pc_d,    m_pcd);
      check("m_pc_p4_d", pc_p4_d, m_p4);
      check("m_valid_d", 32'(valid_d),    32'(m_valid));
      check("m_misalign", 32'(misaligned), 32'(m_mis));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    cyc(); cyc();
    check("rst_pc", pc_f, 32'h0);
    check("rst_instr", instr_d, NOP);
    check("rst_pcd", pc_d, 32'h0);
    check("rst_p4", pc_p4_d, 32'h0);
    check("rst_valid", 32'(valid_d), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    rst = 1'b0;

    // Sequential fetch
    cyc();
    check("seq_pc4", pc_f, 32'h4);
    check("seq_i0", instr_d, 32'h1000_0000);
    check("seq_v1", 32'(valid_d), 32'd1);
    cyc();
    check("seq_pc8", pc_f, 32'h8);
    check("seq_i1", instr_d, 32'h1000_0001);
    cyc();
    check("seq_pcc", pc_f, 32'hC);
    check("seq_i2", instr_d, 32'h1000_0002);
    cyc();
    check("seq_pc10", pc_f, 32'h10);

    // Stall both stages for 3 cycles
    stall_f = 1'b1; stall_d = 1'b1;
    cyc(); cyc(); cyc();
    check("stall_pc", pc_f, 32'h10);
    check("stall_pcd", pc_d, 32'hC);
    check("stall_instr", instr_d, 32'h1000_0003);
    stall_f = 1'b0; stall_d = 1'b0;
    cyc();
    check("resume_pc", pc_f, 32'h14);
    check("resume_pcd", pc_d, 32'h10);
    cyc(); cyc(); cyc(); cyc();
    check("pre_redir_pc", pc_f, 32'h24);

    // Redirect + flush
    pc_src = 1'b1; flush_d = 1'b1; target = 32'h200;
    cyc();
    pc_src = 1'b0; flush_d = 1'b0;
    check("redir_pc", pc_f, 32'h200);
    check("flush_instr", instr_d, NOP);
    check("flush_valid", 32'(valid_d), 32'd0);
    check("flush_pcd", pc_d, 32'h0);
    cyc();
    check("post_redir_pcd", pc_d, 32'h200);
    check("post_redir_valid", 32'(valid_d), 32'd1);
    check("post_redir_instr", instr_d, 32'h1000_0080);

    // Redirect beats stall_f, flush beats stall_d
    pc_src = 1'b1; target = 32'h40; stall_f = 1'b1; stall_d = 1'b1; flush_d = 1'b1;
    cyc();
    pc_src = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    check("prio_pc", pc_f, 32'h40);
    check("prio_valid", 32'(valid_d), 32'd0);
    check("prio_instr", instr_d, NOP);
    cyc();
    check("prio_next_pc", pc_f, 32'h44);

    // Misaligned redirect: one-cycle flag, aligned fetch
    pc_src = 1'b1; target = 32'h106;
    cyc();
    pc_src = 1'b0;
    check("mis_pc", pc_f, 32'h104);
    check("mis_hi", 32'(misaligned), 32'd1);
    cyc();
    check("mis_lo", 32'(misaligned), 32'd0);
    check("mis_next_pc", pc_f, 32'h108);
    pc_src = 1'b1; target = 32'h300;
    cyc();
    pc_src = 1'b0;
    check("aligned_pc", pc_f, 32'h300);
    check("aligned_mis", 32'(misaligned), 32'd0);

    // Wrap at top of address space
    pc_src = 1'b1; target = 32'hFFFF_FFFC;
    cyc();
    pc_src = 1'b0;
    check("wrap_top", pc_f, 32'hFFFF_FFFC);
    cyc();
    check("wrap_pc", pc_f, 32'h0);
    check("wrap_pcd", pc_d, 32'hFFFF_FFFC);
    check("wrap_p4", pc_p4_d, 32'h0);
    check("wrap_instr", instr_d, 32'h4FFF_FFFF);

    // Reset during a stall
    cyc(); cyc();
    stall_f = 1'b1; stall_d = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    check("rst_stall_pc", pc_f, 32'h0);
    check("rst_stall_valid", 32'(valid_d), 32'd0);
    check("rst_stall_instr", instr_d, NOP);
    rst = 1'b0; stall_f = 1'b0; stall_d = 1'b0;
    cyc();
    check("after_rst_pc", pc_f, 32'h4);
    check("after_rst_valid", 32'(valid_d), 32'd1);
    check("after_rst_instr", instr_d, 32'h1000_0000);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
